// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: DM op codes, error codes, FSM states.
package mem_access_unit_pkg;

  localparam logic [2:0] DM_w  = 3'd1;
  localparam logic [2:0] DM_h  = 3'd2;
  localparam logic [2:0] DM_hu = 3'd3;
  localparam logic [2:0] DM_b  = 3'd4;
  localparam logic [2:0] DM_bu = 3'd5;

  localparam logic [1:0] LSU_ERR_OK       = 2'b00;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } lsu_req_t;

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational byte-lane logic: enables, store replication, load extraction/extension, error flags.
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [15:0] hw;
  logic [7:0]  by;

  assign hw = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign by = rdata_i[{addr_lo_i, 3'b000} +: 8];

  // Decode op into lane enables, replicated store data and extended load data
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (op_i)
      DM_w: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = |addr_lo_i;
      end
      DM_h, DM_hu: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = (op_i == DM_h) ? {{16{hw[15]}}, hw} : {16'h0, hw};
        misalign_o = addr_lo_i[0];
        illegal_o  = we_i && (op_i == DM_hu);
      end
      DM_b, DM_bu: begin
        be_o      = 4'b0001 << addr_lo_i;
        wdata_o   = {4{wdata_i[7:0]}};
        rdata_o   = (op_i == DM_b) ? {{24{by[7]}}, by} : {24'h0, by};
        illegal_o = we_i && (op_i == DM_bu);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: accepts one request, runs a req/ack memory transaction, returns data/err.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] resp_pc,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] resp_rdata_q, resp_pc_q;
  logic [1:0]  resp_err_q;

  logic        idle, sel_we;
  logic [2:0]  sel_op;
  logic [1:0]  sel_alo;
  logic [31:0] sel_wdata;
  logic [3:0]  be;
  logic [31:0] wd, ld;
  logic        misalign, illegal;
  logic        accept, bad_req, ack_hit, timeout_hit;

  // In IDLE the lane logic checks the incoming request; afterwards it works on the latched copy
  assign idle      = (state_q == ST_IDLE);
  assign sel_we    = idle ? req_we        : req_q.we;
  assign sel_op    = idle ? req_op        : req_q.op;
  assign sel_alo   = idle ? req_addr[1:0] : req_q.addr[1:0];
  assign sel_wdata = idle ? req_wdata     : req_q.wdata;

  lsu_align u_align (
    .we_i       (sel_we),
    .op_i       (sel_op),
    .addr_lo_i  (sel_alo),
    .wdata_i    (sel_wdata),
    .rdata_i    (mem_rdata),
    .be_o       (be),
    .wdata_o    (wd),
    .rdata_o    (ld),
    .misalign_o (misalign),
    .illegal_o  (illegal)
  );

  assign accept      = idle && req_valid;
  assign bad_req     = misalign || illegal;
  assign ack_hit     = (state_q == ST_REQ) && mem_ack;
  // Fires in the cycle the counter would reach TIMEOUT; an ack in the same cycle takes priority
  assign timeout_hit = (state_q == ST_REQ) && !mem_ack &&
                       (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = bad_req ? ST_RESP : ST_REQ;
      ST_REQ:  if (ack_hit || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; memory lanes only driven while a request is outstanding
  always_comb begin
    req_ready  = idle;
    mem_req    = (state_q == ST_REQ);
    resp_valid = (state_q == ST_RESP);
    mem_we     = mem_req && req_q.we;
    mem_be     = mem_req ? be : 4'b0000;
    mem_wdata  = mem_req ? wd : 32'h0;
  end

  assign mem_addr   = {req_q.addr[31:2], 2'b00};
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign resp_pc    = resp_pc_q;

  // Timeout counter: held at zero outside REQ, counts unacknowledged REQ cycles
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ST_REQ) cnt_d = 16'h0;
    else if (!mem_ack)     cnt_d = cnt_q + 16'd1;
  end

  // Request latch, counter and response registers; illegal op outranks misalignment
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q        <= '0;
      cnt_q        <= 16'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= LSU_ERR_OK;
      resp_pc_q    <= 32'h0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        req_q <= '{we: req_we, op: req_op, addr: req_addr, wdata: req_wdata, pc: req_pc};
        if (bad_req) begin
          resp_err_q   <= illegal ? LSU_ERR_ILLEGAL : LSU_ERR_MISALIGN;
          resp_rdata_q <= 32'h0;
          resp_pc_q    <= req_pc;
        end
      end else if (ack_hit) begin
        resp_err_q   <= LSU_ERR_OK;
        resp_rdata_q <= req_q.we ? 32'h0 : ld;
        resp_pc_q    <= req_q.pc;
      end else if (timeout_hit) begin
        resp_err_q   <= LSU_ERR_TIMEOUT;
        resp_rdata_q <= 32'h0;
        resp_pc_q    <= req_q.pc;
      end
    end
  end

endmodule
